// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: op encodings and the op decoder,
// which the control unit's instruction decoder also uses.
package register_bank_pkg;

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_LOAD   = 2'b01;
   localparam logic [1:0] OP_INC    = 2'b10;
   localparam logic [1:0] OP_CLRDEC = 2'b11;

   // One-hot decoded form of an op. At most one field is set; all zero means NOP.
   typedef struct packed {
      logic load;
      logic inc;
      logic dec;
      logic clr;
   } op_ctl_t;

   // op_dec only matters for OP_CLRDEC, where it chooses DEC over CLR.
   function automatic op_ctl_t decode_op(input logic [1:0] op, input logic op_dec);
      op_ctl_t c;
      c = '0;
      case (op)
         OP_LOAD:   c.load = 1'b1;
         OP_INC:    c.inc  = 1'b1;
         OP_CLRDEC: begin
            if (op_dec) c.dec = 1'b1;
            else        c.clr = 1'b1;
         end
         default:   c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/register_cell.sv
// One DATA_W register with load/inc/dec/clr controls. The controls only take
// effect while en is high, so the bank can share them across all cells.
// wrap_next flags that the op about to be applied rolls the value over.
module register_cell #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic              inc,
   input  logic              dec,
   input  logic              clr,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q,
   output logic              wrap_next
);

   logic [DATA_W-1:0] q_next;

   // Next value: at most one control is active; the priority only guards against misuse.
   always_comb begin
      q_next = q;
      if (en) begin
         if (load)     q_next = d;
         else if (inc) q_next = q + DATA_W'(1);
         else if (dec) q_next = q - DATA_W'(1);
         else if (clr) q_next = '0;
      end
   end

   // Register with async clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= q_next;
   end

   // Rollover: INC of all-ones or DEC of zero.
   assign wrap_next = en & ((inc & (&q)) | (dec & ~(|q)));

endmodule

// File: rtl/register_bank.sv
// NUM_REGS x DATA_W register bank: one modify port (C bus) and two
// combinational read ports (A and B buses), plus a zero flag on A and a
// one-cycle wrap pulse for loop counters. Selects that address a register
// beyond NUM_REGS are ignored on write and read back as zero.
module register_bank
   import register_bank_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int SEL_W    = 3,
   parameter bit BYPASS   = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        op,
   input  logic              op_dec,
   input  logic [SEL_W-1:0]  c_sel,
   input  logic [DATA_W-1:0] c_in,
   input  logic [SEL_W-1:0]  a_sel,
   input  logic [SEL_W-1:0]  b_sel,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              a_zero,
   output logic              wrap
);

   op_ctl_t             ctl;
   logic [NUM_REGS-1:0] c_hit;
   logic [NUM_REGS-1:0] wrap_term;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [DATA_W-1:0]   a_mux;
   logic [DATA_W-1:0]   b_mux;
   logic                load_hit;
   logic                wrap_q;

   assign ctl = decode_op(op, op_dec);

   // One-hot target decode; an out-of-range c_sel yields no hit, so nothing is written.
   always_comb begin
      c_hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         c_hit[i] = (c_sel == SEL_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
      register_cell #(
         .DATA_W(DATA_W)
      ) u_cell (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (c_hit[g]),
         .load      (ctl.load),
         .inc       (ctl.inc),
         .dec       (ctl.dec),
         .clr       (ctl.clr),
         .d         (c_in),
         .q         (regs[g]),
         .wrap_next (wrap_term[g])
      );
   end

   // Read muxes; an out-of-range select matches no register and returns zero.
   always_comb begin
      a_mux = '0;
      b_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (a_sel == SEL_W'(i)) a_mux = regs[i];
         if (b_sel == SEL_W'(i)) b_mux = regs[i];
      end
   end

   // Only a LOAD to an existing register is forwarded, and never while reset holds the
   // bank at zero. A select equal to a valid c_sel is itself valid.
   assign load_hit = ctl.load & (|c_hit) & rst_n;

   assign a_out  = (BYPASS && load_hit && (a_sel == c_sel)) ? c_in : a_mux;
   assign b_out  = (BYPASS && load_hit && (b_sel == c_sel)) ? c_in : b_mux;
   assign a_zero = ~(|a_out);

   // Wrap pulse: reflects only the op of the previous cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wrap_q <= 1'b0;
      else        wrap_q <= |wrap_term;
   end

   assign wrap = wrap_q;

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

   localparam int W = 16;
   localparam logic [1:0] NOP = 2'b00, LD = 2'b01, INC = 2'b10, CD = 2'b11;

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0] op;
   logic op_dec;
   logic [2:0] c_sel, a_sel, b_sel;
   logic [W-1:0] c_in;

   logic [W-1:0] a0, b0, a1, b1, a6, b6;
   logic z0, z1, z6, w0, w1, w6;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: m8 for the 8-register banks, m6 for the 6-register bank.
   logic [W-1:0] m8 [8];
   logic [W-1:0] m6 [8];
   logic w8m, w6m;

   typedef struct {
      logic [W-1:0] a8;
      logic [W-1:0] b8;
      logic         z8;
      logic         w8;
      logic [W-1:0] a6;
      logic [W-1:0] b6;
      logic         w6;
   } exp_t;

   exp_t exp_q[$];

   always #10 clk = ~clk;

   register_bank #(.DATA_W(16), .NUM_REGS(8), .SEL_W(3), .BYPASS(1'b0)) u_bank (
      .clk(clk), .rst_n(rst_n), .op(op), .op_dec(op_dec), .c_sel(c_sel), .c_in(c_in),
      .a_sel(a_sel), .b_sel(b_sel), .a_out(a0), .b_out(b0), .a_zero(z0), .wrap(w0));

   register_bank #(.DATA_W(16), .NUM_REGS(8), .SEL_W(3), .BYPASS(1'b1)) u_byp (
      .clk(clk), .rst_n(rst_n), .op(op), .op_dec(op_dec), .c_sel(c_sel), .c_in(c_in),
      .a_sel(a_sel), .b_sel(b_sel), .a_out(a1), .b_out(b1), .a_zero(z1), .wrap(w1));

   register_bank #(.DATA_W(16), .NUM_REGS(6), .SEL_W(3), .BYPASS(1'b0)) u_six (
      .clk(clk), .rst_n(rst_n), .op(op), .op_dec(op_dec), .c_sel(c_sel), .c_in(c_in),
      .a_sel(a_sel), .b_sel(b_sel), .a_out(a6), .b_out(b6), .a_zero(z6), .wrap(w6));

   always @(posedge clk)
      if (rst_n === 1'b1) assert (!$isunknown(op)) else $error("op is X while out of reset");

   function automatic logic [W-1:0] nxt(input logic [1:0] o, input logic d,
                                        input logic [W-1:0] cur, input logic [W-1:0] data);
      case (o)
         LD:      return data;
         INC:     return cur + 16'd1;
         CD:      return d ? cur - 16'd1 : 16'd0;
         default: return cur;
      endcase
   endfunction

   function automatic logic wr(input logic [1:0] o, input logic d, input logic [W-1:0] cur);
      return (o == INC && cur == 16'hFFFF) || (o == CD && d && cur == 16'h0000);
   endfunction

   task automatic reset_model();
      for (int i = 0; i < 8; i++) begin
         m8[i] = '0;
         m6[i] = '0;
      end
      w8m = 1'b0;
      w6m = 1'b0;
      exp_q.delete();
   endtask

   // Drive one op on the next falling edge and push what the outputs must show after the rising edge.
   task automatic drive_op(input logic [1:0] o, input logic d, input logic [2:0] s,
                           input logic [W-1:0] data, input logic [2:0] as, input logic [2:0] bs);
      exp_t e;
      @(negedge clk);
      op = o; op_dec = d; c_sel = s; c_in = data; a_sel = as; b_sel = bs;
      w8m = wr(o, d, m8[s]);
      m8[s] = nxt(o, d, m8[s], data);
      if (s < 3'd6) begin
         w6m = wr(o, d, m6[s]);
         m6[s] = nxt(o, d, m6[s], data);
      end else begin
         w6m = 1'b0;
      end
      e.a8 = m8[as];
      e.b8 = m8[bs];
      e.z8 = (m8[as] == 16'd0);
      e.w8 = w8m;
      e.a6 = (as < 3'd6) ? m6[as] : 16'd0;
      e.b6 = (bs < 3'd6) ? m6[bs] : 16'd0;
      e.w6 = w6m;
      exp_q.push_back(e);
   endtask

   task automatic cycle(input logic [1:0] o, input logic d, input logic [2:0] s,
                        input logic [W-1:0] data, input logic [2:0] as, input logic [2:0] bs);
      drive_op(o, d, s, data, as, bs);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_sel = 3'(2 * i); b_sel = 3'(2 * i + 1);
         #1;
         vectors++;
         if ({a0, b0, z0, w0} !== {32'h0, 1'b1, 1'b0})
            begin miscompares++; $display("FAIL reset_init: a=%h b=%h z=%b w=%b want 0 0 1 0", a0, b0, z0, w0); end
      end
      reset_model();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) cycle(LD, 1'b0, 3'(i), 16'h1234, 3'(i), 3'(i));
      cycle(LD, 1'b0, 3'd7, 16'hFFFF, 3'd7, 3'd0);
      cycle(INC, 1'b0, 3'd7, 16'h0000, 3'd7, 3'd0);
      vectors++;
      if ({b0, w0} !== {16'h1234, 1'b1})
         begin miscompares++; $display("FAIL reset_preload: b=%h w=%b want 1234 1", b0, w0); end
      exp_q.delete();
      // Reset asserted mid-cycle with a LOAD pending: everything reads 0 before the next edge.
      @(negedge clk);
      op = LD; c_sel = 3'd5; c_in = 16'hAAAA;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_sel = 3'(2 * i); b_sel = 3'(2 * i + 1);
         #1;
         vectors++;
         if ({a0, b0, z0, w0, a1, b1, a6, b6} !== {32'h0, 1'b1, 1'b0, 64'h0})
            begin miscompares++; $display("FAIL reset_mid: sel=%0d a=%h b=%h z=%b w=%b byp=%h/%h six=%h/%h", 2 * i, a0, b0, z0, w0, a1, b1, a6, b6); end
      end
      reset_model();
      @(negedge clk);
      rst_n = 1'b1; op = NOP; a_sel = 3'd5; b_sel = 3'd7;
      #1;
      vectors++;
      if ({a0, b0, w0} !== {32'h0, 1'b0})
         begin miscompares++; $display("FAIL reset_release: a=%h b=%h w=%b want 0 0 0", a0, b0, w0); end
      @(posedge clk); #1;
      vectors++;
      if ({a0, b0, w0} !== {32'h0, 1'b0})
         begin miscompares++; $display("FAIL reset_after_edge: a=%h b=%h w=%b want 0 0 0", a0, b0, w0); end
   endtask

   task automatic test_load_read();
      exp_t e;
      cycle(LD, 1'b0, 3'd3, 16'hBEEF, 3'd3, 3'd5);
      e = exp_q.pop_front();
      vectors++;
      if ({a0, b0, w0} !== {e.a8, e.b8, e.w8})
         begin miscompares++; $display("FAIL load_r3: a=%h b=%h w=%b want %h %h %b", a0, b0, w0, e.a8, e.b8, e.w8); end
      cycle(LD, 1'b1, 3'd5, 16'h0042, 3'd3, 3'd5);
      e = exp_q.pop_front();
      vectors++;
      if ({a0, b0} !== {16'hBEEF, 16'h0042} || {a0, b0} !== {e.a8, e.b8})
         begin miscompares++; $display("FAIL load_r5: a=%h b=%h want beef 0042", a0, b0); end
      for (int i = 0; i < 8; i++) begin
         if (i != 3 && i != 5) begin
            a_sel = 3'(i);
            #1;
            vectors++;
            if (a0 !== 16'h0)
               begin miscompares++; $display("FAIL load_other r%0d: a=%h want 0000", i, a0); end
         end
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      logic [W-1:0] want_a [5] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
      logic         want_w [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0]   ops    [5] = '{LD, INC, NOP, CD, NOP};
      for (int i = 0; i < 5; i++) begin
         cycle(ops[i], 1'b1, 3'd1, 16'hFFFF, 3'd1, 3'd1);
         e = exp_q.pop_front();
         vectors++;
         if ({a0, w0} !== {want_a[i], want_w[i]} || {a0, b0, z0, w0} !== {e.a8, e.b8, e.z8, e.w8})
            begin miscompares++; $display("FAIL wrap step%0d: a=%h w=%b want %h %b", i, a0, w0, want_a[i], want_w[i]); end
      end
   endtask

   task automatic test_rdw();
      exp_t e;
      cycle(LD, 1'b0, 3'd2, 16'h0007, 3'd2, 3'd2);
      e = exp_q.pop_front();
      drive_op(LD, 1'b0, 3'd2, 16'h0099, 3'd2, 3'd2);
      #1;
      vectors++;
      if ({a0, a1, b1, a6} !== {16'h0007, 16'h0099, 16'h0099, 16'h0007})
         begin miscompares++; $display("FAIL rdw_same_cycle: a=%h byp_a=%h byp_b=%h six=%h want 0007 0099 0099 0007", a0, a1, b1, a6); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if ({a0, a1} !== {16'h0099, 16'h0099} || a0 !== e.a8)
         begin miscompares++; $display("FAIL rdw_next: a=%h byp_a=%h want 0099 0099", a0, a1); end
      drive_op(INC, 1'b0, 3'd2, 16'h5555, 3'd2, 3'd2);
      #1;
      vectors++;
      if (a1 !== 16'h0099)
         begin miscompares++; $display("FAIL rdw_inc_nobypass: byp_a=%h want 0099", a1); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if ({a0, a1} !== {16'h009A, 16'h009A} || a0 !== e.a8)
         begin miscompares++; $display("FAIL rdw_inc_after: a=%h byp_a=%h want 009a 009a", a0, a1); end
   endtask

   task automatic test_loop_counter();
      exp_t e;
      logic [1:0] ops   [4] = '{LD, CD, CD, CD};
      logic       want_z[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         cycle(ops[i], 1'b1, 3'd0, 16'd3, 3'd0, 3'd4);
         e = exp_q.pop_front();
         vectors++;
         if ({z0, w0} !== {want_z[i], 1'b0} || {a0, z0} !== {e.a8, e.z8})
            begin miscompares++; $display("FAIL loop step%0d: a=%h z=%b w=%b want z=%b w=0", i, a0, z0, w0, want_z[i]); end
      end
      cycle(LD, 1'b0, 3'd4, 16'd5, 3'd0, 3'd4);
      e = exp_q.pop_front();
      cycle(CD, 1'b0, 3'd4, 16'hFFFF, 3'd0, 3'd4);
      e = exp_q.pop_front();
      vectors++;
      if ({b0, w0} !== {16'h0, 1'b0} || {b0, w0} !== {e.b8, e.w8})
         begin miscompares++; $display("FAIL clr_r4: b=%h w=%b want 0000 0", b0, w0); end
      cycle(CD, 1'b1, 3'd0, 16'h0, 3'd0, 3'd4);
      e = exp_q.pop_front();
      vectors++;
      if ({a0, w0} !== {16'hFFFF, 1'b1})
         begin miscompares++; $display("FAIL dec_zero: a=%h w=%b want ffff 1", a0, w0); end
   endtask

   task automatic test_oob();
      exp_t e;
      cycle(LD, 1'b0, 3'd7, 16'h7777, 3'd6, 3'd7);
      e = exp_q.pop_front();
      vectors++;
      if ({a6, b6, w6, b0} !== {32'h0, 1'b0, 16'h7777} || {a6, b6} !== {e.a6, e.b6})
         begin miscompares++; $display("FAIL oob_load: six a=%h b=%h w=%b main b=%h want 0 0 0 7777", a6, b6, w6, b0); end
      cycle(LD, 1'b0, 3'd7, 16'hFFFF, 3'd7, 3'd6);
      e = exp_q.pop_front();
      cycle(INC, 1'b0, 3'd7, 16'h0, 3'd7, 3'd6);
      e = exp_q.pop_front();
      vectors++;
      if ({w0, w6} !== 2'b10 || {w0, w6} !== {e.w8, e.w6})
         begin miscompares++; $display("FAIL oob_wrap: main w=%b six w=%b want 1 0", w0, w6); end
      for (int i = 0; i < 8; i++) begin
         a_sel = 3'(i);
         #1;
         vectors++;
         if (a6 !== ((i < 6) ? m6[i] : 16'h0))
            begin miscompares++; $display("FAIL oob_read r%0d: six a=%h want %h", i, a6, (i < 6) ? m6[i] : 16'h0); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [W-1:0] data;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0:       data = 16'h0000;
            1:       data = 16'hFFFF;
            default: data = 16'($urandom);
         endcase
         cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               data, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL b2b_queue: no expectation at step %0d", n);
         end else begin
            e = exp_q.pop_front();
            vectors++;
            if ({a0, b0, z0, w0, a1, b1} !== {e.a8, e.b8, e.z8, e.w8, e.a8, e.b8} ||
                {a6, b6, w6} !== {e.a6, e.b6, e.w6})
               begin
                  miscompares++;
                  $display("FAIL b2b step%0d: a=%h b=%h z=%b w=%b byp=%h/%h six=%h/%h/%b want %h %h %b %b six %h/%h/%b",
                           n, a0, b0, z0, w0, a1, b1, a6, b6, w6, e.a8, e.b8, e.z8, e.w8, e.a6, e.b6, e.w6);
               end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish within time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b1; op = NOP; op_dec = 1'b0; c_sel = '0; c_in = '0; a_sel = '0; b_sel = '0;
      reset_model();
      test_reset();
      test_load_read();
      test_wrap();
      test_rdw();
      test_loop_counter();
      test_oob();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
